// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types used across pipeline stages.
package cpu_types_pkg;

    typedef logic [63:0] double_word;
    typedef logic [31:0] instr_word;

    typedef struct packed {
        instr_word  instr;
        double_word pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {instr, pc} entries; flush overrides push and pop.
module fetch_fifo
    import cpu_types_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t pop_data,
    output logic         full,
    output logic         empty,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        full     = (count == CW'(DEPTH));
        empty    = (count == '0);
        do_push  = push && !flush;
        do_pop   = pop && !flush && !empty;
        pop_data = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Pipeline front end: owns the PC, issues credit-limited imem reads, buffers
// returned words for decode and discards wrong-path responses after a redirect.
module instruction_fetch_stage
    import cpu_types_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_write_en,
    input  logic [63:0] pc_write,
    input  logic        halt,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    output logic        fetch_fault
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    double_word    pc;
    double_word    rsp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   in_use;
    logic          fault;
    logic          fifo_full;
    logic          fifo_empty;
    logic          req_fire;
    logic          push;
    logic          pop;
    logic          unused_pc_bit0;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;

    always_comb begin
        in_use         = {1'b0, outstanding} + {1'b0, fifo_count};
        imem_req_valid = !rst && !halt && !fault && !pc_write_en
                         && (in_use < (CW+1)'(FIFO_DEPTH));
        imem_req_addr  = rst ? '0 : pc;
        req_fire       = imem_req_valid && imem_req_ready;
        push           = !rst && imem_rsp_valid && (drop_cnt == '0) && !pc_write_en;
        push_entry     = '{instr: imem_rsp_data, pc: rsp_pc};
        instr_valid    = !rst && !halt && !fifo_empty;
        pop            = instr_valid && instr_ready && !pc_write_en;
        instr          = instr_valid ? head.instr : '0;
        instr_pc       = instr_valid ? head.pc : '0;
        fetch_fault    = fault && !rst;
        unused_pc_bit0 = pc_write[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            fault       <= 1'b0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
            if (pc_write_en) begin
                pc       <= {pc_write[63:2], 2'b00};
                rsp_pc   <= {pc_write[63:2], 2'b00};
                fault    <= pc_write[1];
                // outstanding already includes pending drops, so everything still
                // in flight after this edge is wrong-path and must be discarded
                drop_cnt <= outstanding - CW'(imem_rsp_valid);
            end else begin
                if (req_fire) pc <= pc + 64'd4;
                if (imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
                if (push) rsp_pc <= rsp_pc + 64'd4;
            end
        end
    end

    // Credit accounting keeps outstanding + fifo_count <= FIFO_DEPTH
    always_ff @(posedge clk) begin
        if (push) assert (!fifo_full);
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (pc_write_en),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule
